spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter MAX_ADDR, default 7'h04, highest valid register address.
REQ-002 Parameter ERR_W, default 4, width of the error counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 txn_valid  input  1  decoded SPI transaction present.
REQ-006 txn_rw  input  1  1 = write, 0 = read.
REQ-007 txn_addr  input  7  register address.
REQ-008 txn_data  input  8  write data.
REQ-009 txn_ready  output  1  controller can accept a transaction.
REQ-010 pwm_period_end  input  1  one-cycle pulse at the PWM period boundary.
REQ-011 en_out  output  16  output-enable bits: addr 0x00 drives [7:0], addr 0x01 drives [15:8].
REQ-012 en_pwm  output  16  PWM-mode bits: addr 0x02 drives [7:0], addr 0x03 drives [15:8].
REQ-013 duty  output  8  active PWM duty cycle; addr 0x04 writes it.
REQ-014 commit_pending  output  1  a shadowed duty write awaits commit.
REQ-015 err_count  output  ERR_W  count of rejected transactions, saturating.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, DECODE, WRITE, DONE.
- IDLE: txn_ready = 1, all other states 0.
REQ-017 Handshake: a transaction SHALL be accepted only on an edge where txn_valid && txn_ready = 1.
- On acceptance, txn_rw, txn_addr and txn_data are captured and the FSM goes IDLE->DECODE.
- Inputs are ignored in every other state.
REQ-018 DECODE SHALL select the next state by the captured fields:
- write with addr <= MAX_ADDR: go to WRITE;
- read: go to DONE, no register change, no error;
- write with addr > MAX_ADDR: go to DONE and increment err_count.
REQ-019 WRITE SHALL update the addressed register on the edge leaving WRITE, then go to DONE.
REQ-020 DONE SHALL last one cycle, then return to IDLE.
- Latency: acceptance at edge N; register visible after edge N+2; txn_ready high again after edge N+3.
REQ-021 err_count SHALL saturate at all-ones and never wrap.
REQ-022 txn_valid held high across DONE->IDLE SHALL be accepted again in IDLE (level-sensitive, no edge detection).
REQ-023 Addresses 0x05..MAX_ADDR, if MAX_ADDR is raised, SHALL be accepted and written to no register.

Reset
REQ-024 While rst = 1, all state SHALL be forced immediately, regardless of clk:
- FSM = IDLE, txn_ready = 1;
- en_out = 16'h0000, en_pwm = 16'h0000, duty = 8'h00;
- duty shadow = 8'h00, commit_pending = 0, err_count = 0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no register write.
- The first edge after rst deasserts is a normal IDLE cycle.

Configuration
REQ-026 Macro SPI_REG_CTRL_SHADOW_EN, when defined:
- a duty write loads a shadow register and sets commit_pending;
- duty loads the shadow, and commit_pending clears, on the next edge with pwm_period_end = 1.
REQ-027 If a duty WRITE and pwm_period_end coincide on the same edge:
- duty SHALL take the previous shadow value;
- shadow SHALL take the new data;
- commit_pending SHALL remain 1.
REQ-028 pwm_period_end with commit_pending = 0 SHALL leave duty unchanged.
REQ-029 Macro SPI_REG_CTRL_SHADOW_EN undefined:
- a duty write updates duty directly in WRITE;
- commit_pending is tied 0 and pwm_period_end is ignored.

Verification
REQ-030 Reset, then write 0x00 <- 8'hA5 -> en_out = 16'h00A5 three edges after acceptance; txn_ready low for exactly 3 cycles.
REQ-031 Write 0x07 <- 8'hFF -> no register changes, err_count 0->1; with ERR_W = 4, 16 such writes -> err_count stays 4'hF.
REQ-032 Read addr 0x02 (txn_rw = 0) -> en_pwm unchanged, err_count unchanged, FSM visits DONE and returns to IDLE.
REQ-033 SHADOW_EN defined:
- write 0x04 <- 8'h80 -> duty stays 8'h00, commit_pending = 1;
- pulse pwm_period_end -> duty = 8'h80, commit_pending = 0;
- without the macro, duty = 8'h80 directly after WRITE.
REQ-034 SHADOW_EN defined, shadow = 8'h40 pending, duty write 8'h20 coinciding with pwm_period_end -> duty = 8'h40, shadow = 8'h20, commit_pending = 1.
REQ-035 Assert rst asynchronously during WRITE of 0x03 <- 8'h55 -> en_pwm = 16'h0000 immediately, FSM = IDLE, no write lands.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Register controller for decoded SPI transactions: IDLE/DECODE/WRITE/DONE handshake FSM driving enable, PWM-mode and duty registers.
// Optional macro SPI_REG_CTRL_SHADOW_EN stages duty writes in a shadow register committed at the PWM period boundary.
module spi_reg_ctrl #(
  parameter logic [6:0] MAX_ADDR = 7'h04,
  parameter int         ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txn_valid,
  input  logic             txn_rw,
  input  logic [6:0]       txn_addr,
  input  logic [7:0]       txn_data,
  output logic             txn_ready,
  input  logic             pwm_period_end,
  output logic [15:0]      en_out,
  output logic [15:0]      en_pwm,
  output logic [7:0]       duty,
  output logic             commit_pending,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [6:0] DUTY_ADDR = 7'h04;

  logic [1:0]       state_reg, state_next;
  logic             cap_rw_reg;
  logic [6:0]       cap_addr_reg;
  logic [7:0]       cap_data_reg;
  logic [7:0]       en_byte_reg [4];
  logic [7:0]       duty_reg;
  logic [ERR_W-1:0] err_reg;
  logic             accept;
  logic             wr_strobe;
  logic             addr_bad;

  assign txn_ready = (state_reg == ST_IDLE);
  assign accept    = txn_valid && txn_ready;
  assign wr_strobe = (state_reg == ST_WRITE);
  assign addr_bad  = (cap_addr_reg > MAX_ADDR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_DECODE;
      ST_DECODE: state_next = (cap_rw_reg && !addr_bad) ? ST_WRITE : ST_DONE;
      ST_WRITE:  state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cap_rw_reg   <= 1'b0;
      cap_addr_reg <= 7'h00;
      cap_data_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cap_rw_reg   <= txn_rw;
        cap_addr_reg <= txn_addr;
        cap_data_reg <= txn_data;
      end
    end
  end

  // One byte lane per enable address 0x00..0x03; addresses above 0x04 hit nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_byte_reg[gi] <= 8'h00;
        end else if (wr_strobe && (cap_addr_reg == 7'(gi))) begin
          en_byte_reg[gi] <= cap_data_reg;
        end
      end
    end
  endgenerate

  assign en_out = {en_byte_reg[1], en_byte_reg[0]};
  assign en_pwm = {en_byte_reg[3], en_byte_reg[2]};

  // Only writes beyond MAX_ADDR are rejected; reads of any address are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= '0;
    end else if ((state_reg == ST_DECODE) && cap_rw_reg && addr_bad &&
                 (err_reg != {ERR_W{1'b1}})) begin
      err_reg <= err_reg + ERR_W'(1);
    end
  end

  assign err_count = err_reg;

`ifdef SPI_REG_CTRL_SHADOW_EN
  logic [7:0] shadow_reg;
  logic       pending_reg;
  logic       duty_wr;
  logic       commit;

  assign duty_wr = wr_strobe && (cap_addr_reg == DUTY_ADDR);
  assign commit  = pwm_period_end && pending_reg;

  // A commit coinciding with a new write publishes the old shadow and keeps the new one pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg  <= 8'h00;
      pending_reg <= 1'b0;
      duty_reg    <= 8'h00;
    end else begin
      if (commit) duty_reg <= shadow_reg;
      if (duty_wr) begin
        shadow_reg  <= cap_data_reg;
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign commit_pending = pending_reg;
`else
  logic unused_pwm_period_end;
  assign unused_pwm_period_end = pwm_period_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_reg <= 8'h00;
    end else if (wr_strobe && (cap_addr_reg == DUTY_ADDR)) begin
      duty_reg <= cap_data_reg;
    end
  end

  assign commit_pending = 1'b0;
`endif

  assign duty = duty_reg;

endmodule
